lcd_wr_arbiter: RTL

LCD_WR_ARBITER -- requirements
Module: lcd_wr_arbiter

---
 rtl/lcd_wr_arbiter_if.sv | 31 +++
 rtl/lcd_wr_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/lcd_wr_arbiter_if.sv
// Client write ports, frame-buffer write port and display-sequencer
// handshake of the LCD write arbiter.
interface lcd_wr_arbiter_if;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic          REQ0;
    logic          REQ1;
    logic [AW-1:0] ADR0;
    logic [AW-1:0] ADR1;
    logic [DW-1:0] DAT0;
    logic [DW-1:0] DAT1;
    logic          ACK0;
    logic          ACK1;
    logic          WE;
    logic [AW-1:0] WADR;
    logic [DW-1:0] WDAT;
    logic          LCD_BUSY;
    logic          LCD_START;
    logic          DIRTY;

    modport master (
        output REQ0, REQ1, ADR0, ADR1, DAT0, DAT1, LCD_BUSY,
        input  ACK0, ACK1, WE, WADR, WDAT, LCD_START, DIRTY
    );

    modport slave (
        input  REQ0, REQ1, ADR0, ADR1, DAT0, DAT1, LCD_BUSY,
        output ACK0, ACK1, WE, WADR, WDAT, LCD_START, DIRTY
    );
endinterface

// File: rtl/lcd_wr_arbiter.sv
// Two-client round-robin writer into the LCD frame buffer, plus a
// holdoff/age based refresh trigger for the display sequencer.
module lcd_wr_arbiter #(
    parameter int unsigned HOLDOFF = 15,
    parameter int unsigned MAXLAT  = 1023
) (
    input logic             C,
    input logic             nR,
    lcd_wr_arbiter_if.slave bus
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned HW = 8;
    localparam int unsigned GW = 12;

    localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF);
    localparam logic [GW-1:0] AGE_LIM = GW'(MAXLAT);
    localparam logic [GW-1:0] AGE_MAX = '1;

    typedef enum logic {ARB = 1'b0, WR = 1'b1} state_t;

    state_t        state;
    state_t        state_nx;
    logic          gnt_vld_c;
    logic          gnt_c;
    logic          start_c;
    logic          last;
    logic          we;
    logic          ack0;
    logic          ack1;
    logic          dirty;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdat;
    logic [HW-1:0] hcnt;
    logic [GW-1:0] age;

    always_ff @(posedge C or negedge nR) begin
        if (!nR) state <= ARB;
        else     state <= state_nx;
    end

    // Grant decode: a lone requester wins, a tie goes to the client not served last.
    always_comb begin
        state_nx  = state;
        gnt_vld_c = 1'b0;
        gnt_c     = 1'b0;
        case (state)
            ARB: begin
                if (bus.REQ0 && bus.REQ1) begin
                    gnt_vld_c = 1'b1;
                    gnt_c     = ~last;
                end else if (bus.REQ0 || bus.REQ1) begin
                    gnt_vld_c = 1'b1;
                    gnt_c     = bus.REQ1;
                end
                if (gnt_vld_c) state_nx = WR;
            end
            WR: state_nx = ARB;
        endcase
    end

    // Refresh is only ever requested between writes, never in a WE cycle.
    assign start_c = !we && dirty && !bus.LCD_BUSY && ((hcnt == '0) || (age >= AGE_LIM));

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            last  <= 1'b1;
            we    <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            wadr  <= '0;
            wdat  <= '0;
            dirty <= 1'b0;
            hcnt  <= '0;
            age   <= '0;
        end else begin
            we   <= (state_nx == WR);
            ack0 <= gnt_vld_c && !gnt_c;
            ack1 <= gnt_vld_c && gnt_c;
            if (gnt_vld_c) begin
                last <= gnt_c;
                wadr <= gnt_c ? bus.ADR1 : bus.ADR0;
                wdat <= gnt_c ? bus.DAT1 : bus.DAT0;
            end
            if (we) begin
                dirty <= 1'b1;
                hcnt  <= HOLD_LD;
            end else begin
                if (start_c) dirty <= 1'b0;
                if (dirty && (hcnt != '0)) hcnt <= hcnt - HW'(1);
            end
            if (start_c)                          age <= '0;
            else if (dirty && (age != AGE_MAX))   age <= age + GW'(1);
        end
    end

    assign bus.WE        = we;
    assign bus.ACK0      = ack0;
    assign bus.ACK1      = ack1;
    assign bus.WADR      = wadr;
    assign bus.WDAT      = wdat;
    assign bus.DIRTY     = dirty;
    assign bus.LCD_START = start_c;
endmodule
